// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, state encoding and IR field layout for datapath_ctrl
package ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_MULT = 4'd10;
    localparam logic [3:0] OP_MFHI = 4'd11;
    localparam logic [3:0] OP_MFLO = 4'd12;
    localparam logic [3:0] OP_BEQ  = 4'd13;
    localparam logic [3:0] OP_J    = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Instruction register field positions
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS_MSB    = 8;
    localparam int RS_LSB    = 6;
    localparam int RT_MSB    = 5;
    localparam int RT_LSB    = 3;
    localparam int SHAMT_MSB = 2;
    localparam int SHAMT_LSB = 0;
    localparam int CONST_MSB = 5;
    localparam int CONST_LSB = 0;
    localparam int ADDR_MSB  = 7;
    localparam int ADDR_LSB  = 0;

    // Branch offsets are 6-bit two's complement, widened to PC width
    function automatic logic [7:0] sext6(input logic [5:0] c);
        return {{2{c[5]}}, c};
    endfunction

endpackage

// File: rtl/instr_class.sv
// rtl/instr_class.sv - combinational opcode classifier feeding the control FSM
module instr_class
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_mem,
    output logic       is_load,
    output logic       writes_reg,
    output logic       is_branch,
    output logic       is_mult
);

    // Map each opcode onto the handful of properties the sequencer cares about
    always_comb begin
        is_alu     = 1'b0;
        is_mem     = 1'b0;
        is_load    = 1'b0;
        writes_reg = 1'b0;
        is_branch  = 1'b0;
        is_mult    = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_ADDI: begin
                is_alu     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_LW: begin
                is_mem     = 1'b1;
                is_load    = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SW:            is_mem     = 1'b1;
            OP_MULT:          is_mult    = 1'b1;
            OP_MFHI, OP_MFLO: writes_reg = 1'b1;
            OP_BEQ, OP_J:     is_branch  = 1'b1;
            OP_NOP, OP_HALT:  ;
            default:          ;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter logic [7:0]  RESET_PC    = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        instr_req,
    output logic [7:0]  instr_addr,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    input  logic        eq_flag,
    input  logic        mem_ready,
    output logic [3:0]  opcode,
    output logic [2:0]  rd,
    output logic [2:0]  rs,
    output logic [2:0]  rt,
    output logic [2:0]  shamt,
    output logic [5:0]  constant,
    output logic [7:0]  address,
    output logic [7:0]  pc,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        hilo_write,
    output logic        busy,
    output logic        halted
);

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  pc_q, pc_d;
    logic [3:0]  mult_cnt_q, mult_cnt_d;
    logic        instr_req_q, instr_req_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        reg_write_q, reg_write_d;
    logic        hilo_write_q, hilo_write_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;

    logic is_alu, is_mem, is_load, writes_reg, is_branch, is_mult;
    logic exec_to_wb;

    // Fields are plain slices of the IR, which only changes on the FETCH->DECODE edge
    assign opcode     = ir_q[OPC_MSB:OPC_LSB];
    assign rd         = ir_q[RD_MSB:RD_LSB];
    assign rs         = ir_q[RS_MSB:RS_LSB];
    assign rt         = ir_q[RT_MSB:RT_LSB];
    assign shamt      = ir_q[SHAMT_MSB:SHAMT_LSB];
    assign constant   = ir_q[CONST_MSB:CONST_LSB];
    assign address    = ir_q[ADDR_MSB:ADDR_LSB];
    assign pc         = pc_q;
    assign instr_addr = pc_q;

    assign instr_req  = instr_req_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign reg_write  = reg_write_q;
    assign hilo_write = hilo_write_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

    instr_class u_instr_class (
        .opcode     (opcode),
        .is_alu     (is_alu),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .writes_reg (writes_reg),
        .is_branch  (is_branch),
        .is_mult    (is_mult)
    );

    // ALU results and HI/LO moves both retire through WB; loads get there via MEM
    assign exec_to_wb = is_alu | (writes_reg & ~is_mem);

    // Next state, IR, PC and multiply counter
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        mult_cnt_d = mult_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    pc_d    = pc_q + 8'd1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                mult_cnt_d = 4'd0;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mult) begin
                    if (mult_cnt_q == MULT_LAST) state_d = ST_FETCH;
                    else                         mult_cnt_d = mult_cnt_q + 4'd1;
                end else if (is_mem) begin
                    state_d = ST_MEM;
                end else if (exec_to_wb) begin
                    state_d = ST_WB;
                end else if (is_branch) begin
                    state_d = ST_FETCH;
                    if (opcode == OP_J) pc_d = address;
                    else if (eq_flag)   pc_d = pc_q + sext6(constant);
                end else if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem_ready) state_d = is_load ? ST_WB : ST_FETCH;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register cleanly
    always_comb begin
        instr_req_d  = (state_d == ST_FETCH);
        mem_read_d   = (state_d == ST_MEM) && is_load;
        mem_write_d  = (state_d == ST_MEM) && !is_load;
        reg_write_d  = (state_d == ST_WB);
        hilo_write_d = (state_d == ST_EXEC) && is_mult && (mult_cnt_d == MULT_LAST);
        busy_d       = (state_d != ST_IDLE) && (state_d != ST_HALT);
        halted_d     = (state_d == ST_HALT);
    end

    // Sequencer state and registered outputs; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ir_q         <= 16'h0000;
            pc_q         <= RESET_PC;
            mult_cnt_q   <= 4'd0;
            instr_req_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            hilo_write_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            pc_q         <= pc_d;
            mult_cnt_q   <= mult_cnt_d;
            instr_req_q  <= instr_req_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            hilo_write_q <= hilo_write_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - scoreboard bench for datapath_ctrl
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        eq_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic [3:0]  opcode;
    logic [2:0]  rd, rs, rt, shamt;
    logic [5:0]  constant;
    logic [7:0]  address, pc;
    logic        mem_read, mem_write, reg_write, hilo_write, busy, halted;

    datapath_ctrl #(.MULT_CYCLES(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr(instr),
        .eq_flag(eq_flag), .mem_ready(mem_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt),
        .constant(constant), .address(address), .pc(pc),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .hilo_write(hilo_write), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  strb;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [7:0]  addr;
        logic [7:0]  pc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_act, mon_exp;

    logic [15:0] imem [0:255];
    int          mem_cnt = 0;
    int          sw_delay = 0;
    int          s, s2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // strb = {mem_read, mem_write, reg_write, hilo_write}
    task automatic push_ev(input int c, input logic [3:0] strb, input logic [15:0] ins, input logic [7:0] p);
        ev_t e;
        e.cyc  = c;
        e.strb = strb;
        e.op   = ins[15:12];
        e.rd   = ins[11:9];
        e.rs   = ins[8:6];
        e.rt   = ins[5:3];
        e.addr = ins[7:0];
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Instruction and data memory responders
    initial forever begin
        @(negedge clk);
        instr_valid = instr_req;
        instr       = instr_req ? imem[instr_addr] : 16'h0000;
        if (mem_read || mem_write) begin
            mem_ready = (mem_cnt == (mem_read ? 3 : sw_delay));
            mem_cnt++;
        end else begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end
    end

    // Monitor: every strobe cycle is popped against the scoreboard
    initial forever begin
        @(negedge clk);
        if (mem_read || mem_write || reg_write || hilo_write) begin
            mon_act = '{cyc: cyc, strb: {mem_read, mem_write, reg_write, hilo_write},
                        op: opcode, rd: rd, rs: rs, rt: rt, addr: address, pc: pc};
            checks++;
            if ($countones({mem_read, mem_write, reg_write, hilo_write}) != 1) begin
                failures++;
                $display("FAIL strobe_excl cyc=%0d: got %b required one-hot", cyc, mon_act.strb);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d: got strb=%b op=%h required none", cyc, mon_act.strb, mon_act.op);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp)
                begin
                    failures++;
                    $display("FAIL event: got cyc=%0d strb=%b op=%h rd=%0d rs=%0d rt=%0d addr=%h pc=%h required cyc=%0d strb=%b op=%h rd=%0d rs=%0d rt=%0d addr=%h pc=%h",
                             mon_act.cyc, mon_act.strb, mon_act.op, mon_act.rd, mon_act.rs, mon_act.rt, mon_act.addr, mon_act.pc,
                             mon_exp.cyc, mon_exp.strb, mon_exp.op, mon_exp.rd, mon_exp.rs, mon_exp.rt, mon_exp.addr, mon_exp.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[0]   = 16'h1298;   // ADD rd=1 rs=2 rt=3
        imem[1]   = 16'h7201;   // LW rd=1 address=1
        imem[2]   = 16'hA0D0;   // MULT rs=3 rt=2
        imem[3]   = 16'h0000;   // NOP
        imem[4]   = 16'h8005;   // SW address=5
        imem[5]   = 16'hD03E;   // BEQ constant=-2
        imem[6]   = 16'hE0FF;   // J 0xFF
        imem[255] = 16'h0000;   // NOP, pc wraps to 0
        eq_flag  = 1'b1;
        sw_delay = 0;

        #2;
        chk("reset_pc", {24'h0, pc, instr_addr}, 32'h0);
        chk("reset_fields", {2'b0, opcode, rd, rs, rt, shamt, constant, address}, 32'h0);
        chk("reset_ctrl", {25'h0, instr_req, mem_read, mem_write, reg_write, hilo_write, busy, halted}, 32'h0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        s = cyc;
        push_ev(s + 4, 4'b0010, 16'h1298, 8'h01);
        for (int k = 8; k <= 11; k++) push_ev(s + k, 4'b1000, 16'h7201, 8'h02);
        push_ev(s + 12, 4'b0010, 16'h7201, 8'h02);
        push_ev(s + 18, 4'b0001, 16'hA0D0, 8'h03);
        push_ev(s + 25, 4'b0100, 16'h8005, 8'h05);
        push_ev(s + 32, 4'b0100, 16'h8005, 8'h05);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        chk("fetch_req", {23'h0, instr_req, instr_addr}, {23'h0, 1'b1, 8'h00});
        wait_to(s + 3);
        imem[0] = 16'hF000;     // HALT will be found when pc wraps back to 0
        chk("add_fields", {19'h0, opcode, rd, rs, rt}, {19'h0, 4'd1, 3'd1, 3'd2, 3'd3});
        chk("add_pc", {24'h0, pc}, 32'h01);
        chk("add_busy", {31'h0, busy}, 32'h1);

        wait_to(s + 29);
        chk("beq_taken_pc", {24'h0, pc}, 32'h04);
        eq_flag = 1'b0;
        wait_to(s + 36);
        chk("beq_not_taken_pc", {24'h0, pc}, 32'h06);
        wait_to(s + 39);
        chk("j_pc", {16'h0, pc, instr_addr}, {16'h0, 8'hFF, 8'hFF});
        wait_to(s + 42);
        chk("wrap_pc", {24'h0, pc}, 32'h00);
        wait_to(s + 45);
        chk("halt_entry", {30'h0, halted, busy}, {30'h0, 2'b10});

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("halt_sticky", {21'h0, halted, busy, instr_req, pc}, {21'h0, 1'b1, 1'b0, 1'b0, 8'h01});

        // Reset out of HALT, then reset again in the middle of a stalled store
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        imem[0]  = 16'h8005;
        sw_delay = 20;
        @(negedge clk);
        s2 = cyc;
        push_ev(s2 + 4, 4'b0100, 16'h8005, 8'h01);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(s2 + 4);
        chk("sw_stalled_write", {31'h0, mem_write}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_strobes", {28'h0, mem_read, mem_write, reg_write, hilo_write}, 32'h0);
        chk("rst_async_pc", {24'h0, pc}, 32'h00);
        chk("rst_async_ctrl", {29'h0, busy, halted, instr_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", {22'h0, busy, instr_req, pc}, 32'h0);
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle control FSM that sequences the 16-bit DATAPATH.
- Fetches 16-bit instructions over a req/valid handshake and splits each into the DATAPATH field inputs (opcode, rd, rs, rt, shamt, constant, address).
- Owns the PC.
- Drives mem_read, mem_write and reg_write with correct per-state timing, stalling on memory and on a multi-cycle multiply.

Parameters:
- MULT_CYCLES, 4, number of EXEC cycles held for MULT (legal range 1..15).
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that leaves IDLE.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  8  fetch address; always equals pc.
- instr_valid  in  1  instr is valid; sampled only while instr_req=1.
- instr  in  16  fetched instruction word.
- eq_flag  in  1  DATAPATH rs_data==rt_data, valid in EXEC.
- mem_ready  in  1  data memory has completed the access.
- opcode  out  4  instr[15:12].
- rd  out  3  instr[11:9].
- rs  out  3  instr[8:6].
- rt  out  3  instr[5:3].
- shamt  out  3  instr[2:0].
- constant  out  6  instr[5:0].
- address  out  8  instr[7:0].
- pc  out  8  current PC.
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write strobe.
- reg_write  out  1  register file write enable.
- hilo_write  out  1  HI/LO write enable.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in the HALT state.

Behaviour:
- Opcode map:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR
  - 5 SLL, 6 SRL
  - 7 LW, 8 SW
  - 9 ADDI
  - 10 MULT
  - 11 MFHI, 12 MFLO
  - 13 BEQ, 14 J
  - 15 HALT
- Reset (asynchronous, immediate): state=IDLE, pc=RESET_PC, instruction register (IR)=0. All field outputs are 0, all strobes are 0, busy=0, halted=0.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH. start is ignored in every other state.
- FETCH:
  - instr_req=1, instr_addr=pc.
  - On instr_valid=1: IR<=instr, pc<=pc+1 (mod 256, 255 wraps to 0), -> DECODE.
  - Otherwise wait indefinitely.
- DECODE: field outputs take their IR values. Fields hold stable until the next DECODE. -> EXEC.
- EXEC:
  - Default: 1 cycle.
  - MULT: EXEC is held exactly MULT_CYCLES cycles. hilo_write=1 on the last cycle only, then -> FETCH.
  - BEQ: if eq_flag=1, pc<=pc+sign_extend(constant), mod 256, applied to the already-incremented pc. -> FETCH.
  - J: pc<=address. -> FETCH.
  - NOP: -> FETCH.
  - LW/SW: -> MEM.
  - ALU ops, ADDI, MFHI, MFLO: -> WB.
  - HALT: -> HALT.
- MEM:
  - mem_read=1 (LW) or mem_write=1 (SW), held every cycle until mem_ready=1 is sampled.
  - On mem_ready=1: LW -> WB, SW -> FETCH. The strobe deasserts on the following cycle.
  - mem_ready outside MEM is ignored.
- WB: reg_write=1 for exactly one cycle, -> FETCH.
- HALT: halted=1, busy=0. Exit only via rst.
- Latency with zero-wait fetch and memory:
  - ALU/ADDI/MFHI/MFLO: 4 cycles.
  - LW: 5.
  - SW: 4.
  - BEQ/J/NOP: 3.
  - MULT: 2+MULT_CYCLES.
- Strobe exclusivity: at most one of mem_read, mem_write, reg_write, hilo_write is high in any cycle.
- Reset mid-operation (e.g. during MEM): all strobes drop asynchronously and pc returns to RESET_PC.

Decomposition:
- Shared package ctrl_pkg:
  - opcode localparams OP_NOP..OP_HALT.
  - state encoding.
  - IR field bit positions.
- One sub-module: instr_class, combinational. Input is opcode. Outputs are is_alu, is_mem, is_load, writes_reg, is_branch, is_mult.

Test Plan:
- Reset, start, fetch 16'h1298 (ADD rd=1 rs=2 rt=3) with instant valid -> opcode=1, rd=1, rs=2, rt=3. reg_write=1 on cycle 4 only. pc=1.
- LW 16'h7201 with mem_ready delayed 3 cycles -> mem_read high exactly 4 cycles, address=1. reg_write one cycle later. No other strobe overlap.
- BEQ constant=6'h3E (-2) at pc=5 with eq_flag=1 -> pc=4. Same instruction with eq_flag=0 -> pc=6.
- MULT with MULT_CYCLES=4 -> EXEC lasts 4 cycles, hilo_write pulses once on the 4th, reg_write stays 0.
- J address=8'hFF, then a NOP fetched at 255 -> pc wraps to 0. HALT -> halted=1, busy=0, later start pulses ignored.
- Assert rst during MEM with mem_write=1 -> mem_write=0 and pc=0 before the next clock edge. State returns to IDLE.
